// File: rtl/ahb_bus_mux.sv
// ahb_bus_mux: single-master AHB-Lite decoder / response mux.
// Decodes the address phase into per-slave selects. Tracks which slave owns
// the current data phase and muxes that slave's response back to the master.
// Unmapped transfers are answered by a built-in default slave (DS). DS
// returns the two-cycle ERROR response and keeps a saturating error count.
module ahb_bus_mux #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE = 32'h4000_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  output logic        hsel_s0,
  output logic        hsel_s1,
  output logic        hsel_s2,
  input  logic [31:0] hrdata_s0,
  input  logic [31:0] hrdata_s1,
  input  logic [31:0] hrdata_s2,
  input  logic        hreadyout_s0,
  input  logic        hreadyout_s1,
  input  logic        hreadyout_s2,
  input  logic [1:0]  hresp_s0,
  input  logic [1:0]  hresp_s1,
  input  logic [1:0]  hresp_s2,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] SEL_DS = 2'd3;

  typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_state_e;

  logic [1:0] dec_sel;
  logic [1:0] dsel;
  logic       ds_act;
  logic       ds_req;
  ds_state_e  ds_state;
  logic       ds_rdy;
  logic [1:0] ds_rsp;

  // Address decode, S0 wins over S1 wins over S2; no match -> default slave
  always_comb begin
    dec_sel = SEL_DS;
    if      ((haddr & S0_MASK) == S0_BASE) dec_sel = 2'd0;
    else if ((haddr & S1_MASK) == S1_BASE) dec_sel = 2'd1;
    else if ((haddr & S2_MASK) == S2_BASE) dec_sel = 2'd2;
  end

  assign hsel_s0 = (dec_sel == 2'd0);
  assign hsel_s1 = (dec_sel == 2'd1);
  assign hsel_s2 = (dec_sel == 2'd2);

  // An active (NONSEQ/SEQ) transfer aimed at the default slave
  assign ds_req = (dec_sel == SEL_DS) & htrans[1];

  // Data-phase owner and DS-active flag advance only when the bus is ready
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dsel   <= SEL_DS;
      ds_act <= 1'b0;
    end else if (hready) begin
      dsel   <= dec_sel;
      ds_act <= ds_req;
    end
  end

  // Default-slave FSM with registered ready/response and the error counter
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ds_state <= DS_OK;
      ds_rdy   <= 1'b1;
      ds_rsp   <= 2'b00;
      err_cnt  <= 8'h00;
    end else begin
      case (ds_state)
        DS_ERR1: begin
          ds_state <= DS_ERR2;
          ds_rdy   <= 1'b1;
          ds_rsp   <= 2'b01;
        end
        default: begin
          // DS_OK and DS_ERR2 share the same next-transfer evaluation
          if (hready) begin
            if (ds_req) begin
              ds_state <= DS_ERR1;
              ds_rdy   <= 1'b0;
              ds_rsp   <= 2'b01;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
            end else begin
              ds_state <= DS_OK;
              ds_rdy   <= 1'b1;
              ds_rsp   <= 2'b00;
            end
          end
        end
      endcase
    end
  end

  // Response mux by data-phase owner; DS only reports its FSM while active
  always_comb begin
    hrdata = 32'h0;
    hready = 1'b1;
    hresp  = 2'b00;
    case (dsel)
      2'd0: begin hrdata = hrdata_s0; hready = hreadyout_s0; hresp = hresp_s0; end
      2'd1: begin hrdata = hrdata_s1; hready = hreadyout_s1; hresp = hresp_s1; end
      2'd2: begin hrdata = hrdata_s2; hready = hreadyout_s2; hresp = hresp_s2; end
      default: begin
        if (ds_act) begin
          hready = ds_rdy;
          hresp  = ds_rsp;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_bus_mux.sv
// Testbench for ahb_bus_mux: directed test-plan sequences plus randomized
// traffic, all checked against a transaction-level reference model.
module tb_ahb_bus_mux;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hsel_s0, hsel_s1, hsel_s2;
  logic [31:0] hrdata_s0 = 32'h0, hrdata_s1 = 32'h0, hrdata_s2 = 32'h0;
  logic        hreadyout_s0 = 1'b1, hreadyout_s1 = 1'b1, hreadyout_s2 = 1'b1;
  logic [1:0]  hresp_s0 = 2'b00, hresp_s1 = 2'b00, hresp_s2 = 2'b00;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [7:0]  err_cnt;

  ahb_bus_mux dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hsel_s0(hsel_s0), .hsel_s1(hsel_s1), .hsel_s2(hsel_s2),
    .hrdata_s0(hrdata_s0), .hrdata_s1(hrdata_s1), .hrdata_s2(hrdata_s2),
    .hreadyout_s0(hreadyout_s0), .hreadyout_s1(hreadyout_s1), .hreadyout_s2(hreadyout_s2),
    .hresp_s0(hresp_s0), .hresp_s1(hresp_s1), .hresp_s2(hresp_s2),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .err_cnt(err_cnt)
  );

  always #5 hclk = ~hclk;

  int n_vec = 0;
  int n_err = 0;

  // Slave-side values to present next cycle (copied onto the bus at negedge)
  logic [31:0] nx_rd [3];
  logic        nx_rdy [3];
  logic [1:0]  nx_rsp [3];
  bit          rnd_slaves = 0;

  // Reference model: who owns the data phase and how many DS error cycles remain
  int owner    = 3;
  int err_left = 0;
  int cnt      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:16] == 16'h2000) return 1;
    if (a[31:16] == 16'h4000) return 2;
    return 3;
  endfunction

  // Expected bus response for the current data phase
  task automatic model_out(output logic [31:0] rd, output logic rdy, output logic [1:0] rsp);
    if (owner < 3) begin
      rd = nx_rd[owner]; rdy = nx_rdy[owner]; rsp = nx_rsp[owner];
    end else begin
      rd  = 32'h0;
      rdy = (err_left != 2);
      rsp = (err_left != 0) ? 2'b01 : 2'b00;
    end
  endtask

  // One bus cycle: entered at a negedge, returns at the next negedge
  task automatic step(input logic [31:0] a, input logic [1:0] t);
    logic [31:0] e_rd;
    logic        e_rdy;
    logic [1:0]  e_rsp;
    int          d;
    if (rnd_slaves) begin
      for (int i = 0; i < 3; i++) begin
        nx_rd[i]  = $urandom;
        nx_rdy[i] = ($urandom_range(0, 3) != 0);
        nx_rsp[i] = 2'($urandom_range(0, 1));
      end
    end
    haddr = a; htrans = t;
    hrdata_s0 = nx_rd[0]; hrdata_s1 = nx_rd[1]; hrdata_s2 = nx_rd[2];
    hreadyout_s0 = nx_rdy[0]; hreadyout_s1 = nx_rdy[1]; hreadyout_s2 = nx_rdy[2];
    hresp_s0 = nx_rsp[0]; hresp_s1 = nx_rsp[1]; hresp_s2 = nx_rsp[2];
    #2;
    d = decode(a);
    model_out(e_rd, e_rdy, e_rsp);
    chk("hsel_s0", 32'(hsel_s0), 32'(d == 0));
    chk("hsel_s1", 32'(hsel_s1), 32'(d == 1));
    chk("hsel_s2", 32'(hsel_s2), 32'(d == 2));
    chk("hrdata",  hrdata, e_rd);
    chk("hready",  32'(hready), 32'(e_rdy));
    chk("hresp",   32'(hresp), 32'(e_rsp));
    chk("err_cnt", 32'(err_cnt), 32'(cnt));
    @(posedge hclk);
    if (e_rdy) begin
      owner = d;
      if (d == 3 && t[1]) begin
        err_left = 2;
        if (cnt < 255) cnt++;
      end else err_left = 0;
    end else if (err_left == 2) err_left = 1;
    @(negedge hclk);
  endtask

  // Asynchronous reset pulse starting just after a negedge; returns at a negedge
  task automatic do_reset();
    #1 hresetn = 1'b0;
    #1;
    chk("rst_hready",  32'(hready), 32'd1);
    chk("rst_hresp",   32'(hresp), 32'd0);
    chk("rst_hrdata",  hrdata, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    owner = 3; err_left = 0; cnt = 0;
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  localparam logic [31:0] UNMAP = 32'h8000_0000;

  initial begin
    for (int i = 0; i < 3; i++) begin
      nx_rd[i] = 32'h0; nx_rdy[i] = 1'b1; nx_rsp[i] = 2'b00;
    end
    @(negedge hclk);
    do_reset();

    // IDLE to SRAM: select S0, zero-wait OKAY
    step(32'h0000_0010, 2'b00);
    step(32'h0000_0010, 2'b00);

    // SRAM read with two stall cycles
    step(32'h0000_0004, 2'b10);
    nx_rdy[0] = 1'b0; nx_rd[0] = 32'h0;
    step(32'h0000_0000, 2'b00);
    step(32'h0000_0000, 2'b00);
    nx_rdy[0] = 1'b1; nx_rd[0] = 32'hDEADBEEF;
    step(32'h0000_0000, 2'b00);

    // Pipelined S0 write then S1 read
    nx_rd[1] = 32'h1234_5678;
    step(32'h0000_0000, 2'b10);
    nx_rdy[0] = 1'b0;
    step(32'h2000_0008, 2'b10);
    nx_rdy[0] = 1'b1;
    step(32'h2000_0008, 2'b10);
    step(32'h0000_0000, 2'b00);

    // Unmapped NONSEQ -> ERROR, then unmapped IDLE -> OKAY
    step(UNMAP, 2'b10);
    step(32'h0000_0000, 2'b00);
    step(32'h0000_0000, 2'b00);
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    step(UNMAP, 2'b00);
    step(32'h0000_0000, 2'b00);
    chk("err_cnt_idle", 32'(err_cnt), 32'd1);

    // Master cancels with IDLE during ERR1; response must still complete
    step(UNMAP, 2'b10);
    step(UNMAP, 2'b00);
    step(UNMAP, 2'b00);
    chk("err_cnt_cancel", 32'(err_cnt), 32'd2);

    // Back-to-back unmapped SEQ until saturation (address held through ERR1)
    for (int i = 0; i < 260; i++) begin
      step(UNMAP, 2'b11);
      step(UNMAP, 2'b11);
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    step(32'h0000_0000, 2'b00);
    step(32'h0000_0000, 2'b00);

    // Reset while in DS_ERR1
    step(UNMAP, 2'b10);
    do_reset();
    step(32'h0000_0000, 2'b00);

    // Reset while S1 owns the data phase with nonzero read data
    step(32'h2000_0008, 2'b10);
    do_reset();
    step(32'h4000_0100, 2'b10);
    step(32'h0000_FFFC, 2'b10);
    step(32'h0001_0000, 2'b10);
    step(32'h0000_0000, 2'b00);

    // Randomized traffic with random slave behaviour
    rnd_slaves = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0: a = {16'h0000, 16'($urandom)};
        1: a = {16'h2000, 16'($urandom)};
        2: a = {16'h4000, 16'($urandom)};
        3: a = {16'h0001, 16'($urandom)};
        4: a = $urandom;
        default: a = UNMAP;
      endcase
      step(a, 2'($urandom_range(0, 3)));
      if (i == 1500) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
